wb_arbiter_2to1: RTL and testbench

- Pipelined Wishbone arbiter that shares one Wishbone slave between two masters. The slave is the wb_to_spi_master flash port.
- Port 0 is the UART-driven serial_wb_master. Port 1 is a local requester, e.g. a boot-image verifier.
- Grants whole bus cycles (cyc-to-cyc) with round-robin fairness, tracks outstanding transfers and bounds them.
- Sits between the masters and the SPI flash master in the bootstrap top level.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_outstanding_ctr.sv | 47 ++++
 rtl/wb_arbiter_2to1.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter_2to1.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus widths, arbiter state encoding
// and the round-robin pick used by the 2:1 arbiter.
package wb_pkg;

  localparam int unsigned WB_ADDR_BITS       = 8;
  localparam int unsigned WB_BYTES           = 1;
  localparam int unsigned WB_SEL_WIDTH       = 1;
  localparam int unsigned WB_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Returns 1 when port 1 should win; on a tie the port that did not own last wins.
  function automatic logic rr_pick_port1(input logic cyc0, input logic cyc1,
                                         input logic last_owner);
    return (cyc0 & cyc1) ? ~last_owner : cyc1;
  endfunction

endpackage

// File: rtl/wb_outstanding_ctr.sv
// Up/down counter of accepted-but-unacknowledged Wishbone transfers with a
// registered full flag and a synchronous clear for aborted cycles.
module wb_outstanding_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  // Saturating at both ends; a simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else if (!inc_i && dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d = (count_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Pipelined Wishbone 2:1 arbiter: grants whole cyc-to-cyc bus cycles
// round-robin and bounds the number of outstanding transfers.
module wb_arbiter_2to1
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_BITS       = WB_ADDR_BITS,
  parameter int unsigned BYTES           = WB_BYTES,
  parameter int unsigned SEL_WIDTH       = WB_SEL_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = WB_MAX_OUTSTANDING
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [ADDR_BITS-1:0] s0_wb_addr,
  input  logic [BYTES*8-1:0]   s0_wb_dat_m2s,
  output logic [BYTES*8-1:0]   s0_wb_dat_s2m,
  input  logic                 s0_wb_we,
  input  logic [SEL_WIDTH-1:0] s0_wb_sel,
  input  logic                 s0_wb_stb,
  input  logic                 s0_wb_cyc,
  output logic                 s0_wb_ack,
  output logic                 s0_wb_stall,
  input  logic [ADDR_BITS-1:0] s1_wb_addr,
  input  logic [BYTES*8-1:0]   s1_wb_dat_m2s,
  output logic [BYTES*8-1:0]   s1_wb_dat_s2m,
  input  logic                 s1_wb_we,
  input  logic [SEL_WIDTH-1:0] s1_wb_sel,
  input  logic                 s1_wb_stb,
  input  logic                 s1_wb_cyc,
  output logic                 s1_wb_ack,
  output logic                 s1_wb_stall,
  output logic [ADDR_BITS-1:0] m_wb_addr,
  output logic [BYTES*8-1:0]   m_wb_dat_m2s,
  input  logic [BYTES*8-1:0]   m_wb_dat_s2m,
  output logic                 m_wb_we,
  output logic [SEL_WIDTH-1:0] m_wb_sel,
  output logic                 m_wb_stb,
  output logic                 m_wb_cyc,
  input  logic                 m_wb_ack,
  input  logic                 m_wb_stall,
  output logic [1:0]           grant
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [1:0]       grant_q, grant_d;

  logic             own0, own1, owned;
  logic             full;
  logic [CNT_W-1:0] outstanding;
  logic             ctr_inc, ctr_dec, ctr_clr;

  assign own0  = (state_q == OWN0);
  assign own1  = (state_q == OWN1);
  assign owned = own0 | own1;
  assign grant = grant_q;

  // Bus ownership FSM; every handover passes through IDLE.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (s0_wb_cyc || s1_wb_cyc) begin
          state_d = rr_pick_port1(s0_wb_cyc, s1_wb_cyc, last_owner_q) ? OWN1 : OWN0;
        end
      end
      OWN0: begin
        if (!s0_wb_cyc) begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
        end
      end
      OWN1: begin
        if (!s1_wb_cyc) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == OWN1, state_d == OWN0};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
    end
  end

  // Steer the owner onto the slave; the idle port sees stall and no ack/data.
  always_comb begin
    m_wb_cyc      = 1'b0;
    m_wb_stb      = 1'b0;
    m_wb_addr     = '0;
    m_wb_dat_m2s  = '0;
    m_wb_we       = 1'b0;
    m_wb_sel      = '0;
    s0_wb_dat_s2m = '0;
    s0_wb_ack     = 1'b0;
    s0_wb_stall   = 1'b1;
    s1_wb_dat_s2m = '0;
    s1_wb_ack     = 1'b0;
    s1_wb_stall   = 1'b1;
    if (own0) begin
      m_wb_cyc      = s0_wb_cyc;
      m_wb_stb      = s0_wb_cyc & s0_wb_stb & ~full;
      m_wb_addr     = s0_wb_addr;
      m_wb_dat_m2s  = s0_wb_dat_m2s;
      m_wb_we       = s0_wb_we;
      m_wb_sel      = s0_wb_sel;
      s0_wb_stall   = m_wb_stall | full;
      s0_wb_ack     = m_wb_ack;
      s0_wb_dat_s2m = m_wb_dat_s2m;
    end else if (own1) begin
      m_wb_cyc      = s1_wb_cyc;
      m_wb_stb      = s1_wb_cyc & s1_wb_stb & ~full;
      m_wb_addr     = s1_wb_addr;
      m_wb_dat_m2s  = s1_wb_dat_m2s;
      m_wb_we       = s1_wb_we;
      m_wb_sel      = s1_wb_sel;
      s1_wb_stall   = m_wb_stall | full;
      s1_wb_ack     = m_wb_ack;
      s1_wb_dat_s2m = m_wb_dat_s2m;
    end
  end

  // Acks in IDLE are stray responses from an aborted cycle and are not counted.
  assign ctr_inc = m_wb_stb & ~m_wb_stall;
  assign ctr_dec = m_wb_ack & owned & (outstanding != '0);
  assign ctr_clr = (own0 & ~s0_wb_cyc) | (own1 & ~s1_wb_cyc);

  wb_outstanding_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_ctr (
    .clk    (clk),
    .rst_n  (aresetn),
    .clr_i  (ctr_clr),
    .inc_i  (ctr_inc),
    .dec_i  (ctr_dec),
    .count_o(outstanding),
    .full_o (full)
  );

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed scoreboard bench for wb_arbiter_2to1: expected acks are queued by
// the stimulus and retired by a monitor watching s0/s1_wb_ack.
module tb_wb_arbiter_2to1;

  logic       clk;
  logic       aresetn;
  logic [7:0] s0_addr, s0_dm2s, s0_ds2m, s1_addr, s1_dm2s, s1_ds2m;
  logic       s0_we, s0_sel, s0_stb, s0_cyc, s0_ack, s0_stall;
  logic       s1_we, s1_sel, s1_stb, s1_cyc, s1_ack, s1_stall;
  logic [7:0] m_addr, m_dm2s, m_ds2m;
  logic       m_we, m_sel, m_stb, m_cyc, m_ack, m_stall;
  logic [1:0] grant;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   s0_ack_cnt = 0;
  int   s1_ack_cnt = 0;
  int   acc_cnt  = 0;
  int   base0, base1, acc_base;

  wb_arbiter_2to1 dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s0_wb_addr   (s0_addr),
    .s0_wb_dat_m2s(s0_dm2s),
    .s0_wb_dat_s2m(s0_ds2m),
    .s0_wb_we     (s0_we),
    .s0_wb_sel    (s0_sel),
    .s0_wb_stb    (s0_stb),
    .s0_wb_cyc    (s0_cyc),
    .s0_wb_ack    (s0_ack),
    .s0_wb_stall  (s0_stall),
    .s1_wb_addr   (s1_addr),
    .s1_wb_dat_m2s(s1_dm2s),
    .s1_wb_dat_s2m(s1_ds2m),
    .s1_wb_we     (s1_we),
    .s1_wb_sel    (s1_sel),
    .s1_wb_stb    (s1_stb),
    .s1_wb_cyc    (s1_cyc),
    .s1_wb_ack    (s1_ack),
    .s1_wb_stall  (s1_stall),
    .m_wb_addr    (m_addr),
    .m_wb_dat_m2s (m_dm2s),
    .m_wb_dat_s2m (m_ds2m),
    .m_wb_we      (m_we),
    .m_wb_sel     (m_sel),
    .m_wb_stb     (m_stb),
    .m_wb_cyc     (m_cyc),
    .m_wb_ack     (m_ack),
    .m_wb_stall   (m_stall),
    .grant        (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int port, input logic [7:0] dat);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ack port=%0d got_ack=1 exp_ack=0 data=0x%0h", port, dat);
    end else begin
      e = exp_q.pop_front();
      check("sb_ack_port", 32'(port), 32'(e.port));
      check("sb_ack_data", 32'(dat), 32'(e.data));
    end
  endtask

  // Monitor: every ack seen on a master port must match the next queued response.
  always @(negedge clk) begin
    if (aresetn) begin
      if (m_stb && !m_stall) acc_cnt++;
      if (s0_ack) begin
        s0_ack_cnt++;
        sb_pop(0, s0_ds2m);
      end
      if (s1_ack) begin
        s1_ack_cnt++;
        sb_pop(1, s1_ds2m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 aresetn = 1'b0;
    @(posedge clk);
    #3 aresetn = 1'b1;
    step();
  endtask

  task automatic check_s1_blocked(input string tag);
    check({tag, "_s1_stall"}, 32'(s1_stall), 32'd1);
    check({tag, "_s1_ack"}, 32'(s1_ack), 32'd0);
    check({tag, "_s1_dat"}, 32'(s1_ds2m), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    {s0_addr, s0_dm2s, s0_we, s0_sel, s0_stb, s0_cyc} = '0;
    {s1_addr, s1_dm2s, s1_we, s1_sel, s1_stb, s1_cyc} = '0;
    {m_ds2m, m_ack, m_stall} = '0;
    #13;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_m_cyc", 32'(m_cyc), 32'd0);
    check("rst_m_stb", 32'(m_stb), 32'd0);
    check("rst_s0_stall", 32'(s0_stall), 32'd1);
    check("rst_s1_stall", 32'(s1_stall), 32'd1);
    check("rst_s0_ack", 32'(s0_ack), 32'd0);
    check("rst_s1_ack", 32'(s1_ack), 32'd0);
    #10 aresetn = 1'b1;
    step();

    // 1: single write from port 0, slave acks two cycles after acceptance
    base0 = s0_ack_cnt;
    s0_cyc = 1; s0_stb = 1; s0_we = 1; s0_sel = 1; s0_addr = 8'h12; s0_dm2s = 8'hA5;
    @(negedge clk);
    check("t1_grant_latency", 32'(grant), 32'd0);
    step();
    check("t1_grant", 32'(grant), 32'd1);
    check("t1_m_addr", 32'(m_addr), 32'h12);
    check("t1_m_dat", 32'(m_dm2s), 32'hA5);
    check("t1_m_we", 32'(m_we), 32'd1);
    check("t1_m_stb", 32'(m_stb), 32'd1);
    check("t1_s1_stall", 32'(s1_stall), 32'd1);
    step();
    s0_stb = 0;
    step();
    m_ack = 1; m_ds2m = 8'h00;
    exp_q.push_back('{0, 8'h00});
    step();
    m_ack = 0; s0_cyc = 0; s0_we = 0;
    step();
    check("t1_idle_grant", 32'(grant), 32'd0);
    check("t1_s0_ack_count", 32'(s0_ack_cnt - base0), 32'd1);
    check("t1_s1_stall_end", 32'(s1_stall), 32'd1);

    // 2: round-robin on simultaneous requests
    do_reset();
    s0_cyc = 1; s1_cyc = 1;
    step();
    check("t2_first_grant", 32'(grant), 32'd1);
    s0_cyc = 0;
    step();
    check("t2_idle_gap", 32'(grant), 32'd0);
    step();
    check("t2_second_grant", 32'(grant), 32'd2);
    s1_cyc = 0;
    step();
    check("t2_idle2", 32'(grant), 32'd0);
    s0_cyc = 1; s1_cyc = 1;
    step();
    check("t2_third_grant", 32'(grant), 32'd1);
    s0_cyc = 0; s1_cyc = 0;
    step();
    check("t2_idle3", 32'(grant), 32'd0);

    // 3: outstanding limit with a silent slave
    acc_base = acc_cnt;
    s0_cyc = 1; s0_stb = 1; s0_addr = 8'h20;
    for (int i = 0; i < 5; i++) step();
    check("t3_accepted", 32'(acc_cnt - acc_base), 32'd4);
    check("t3_s0_stall_full", 32'(s0_stall), 32'd1);
    check("t3_m_stb_full", 32'(m_stb), 32'd0);
    check("t3_outstanding", 32'(dut.outstanding), 32'd4);
    m_ack = 1; m_ds2m = 8'h3C;
    exp_q.push_back('{0, 8'h3C});
    step();
    check("t3_m_stb_after_ack", 32'(m_stb), 32'd1);
    check("t3_s0_stall_after_ack", 32'(s0_stall), 32'd0);
    m_ack = 0;
    step();
    check("t3_m_stb_refull", 32'(m_stb), 32'd0);
    step();
    check("t3_accepted_total", 32'(acc_cnt - acc_base), 32'd5);
    s0_stb = 0; s0_cyc = 0;
    step();
    check("t3_idle", 32'(grant), 32'd0);
    check("t3_ctr_cleared", 32'(dut.outstanding), 32'd0);

    // 4: abort with two outstanding; late acks go nowhere, stb without cyc ignored
    s0_cyc = 1; s0_stb = 1; s0_addr = 8'h30;
    step();
    check("t4_grant", 32'(grant), 32'd1);
    step();
    step();
    check("t4_outstanding", 32'(dut.outstanding), 32'd2);
    s0_stb = 0; s0_cyc = 0;
    step();
    check("t4_idle", 32'(grant), 32'd0);
    check("t4_ctr_cleared", 32'(dut.outstanding), 32'd0);
    check("t4_m_cyc", 32'(m_cyc), 32'd0);
    m_ack = 1; m_ds2m = 8'h77; s1_stb = 1;
    #1;
    check("t4_late_s0_ack", 32'(s0_ack), 32'd0);
    check("t4_late_s1_ack", 32'(s1_ack), 32'd0);
    check("t4_stb_no_cyc", 32'(m_stb), 32'd0);
    step();
    check("t4_no_grant", 32'(grant), 32'd0);
    check("t4_late2_s0_ack", 32'(s0_ack), 32'd0);
    m_ack = 0; s1_stb = 0;
    step();
    check("t4_still_idle", 32'(grant), 32'd0);

    // 5: s1 waits while s0 runs a 3-read burst
    base0 = s0_ack_cnt; base1 = s1_ack_cnt;
    s0_cyc = 1; s0_stb = 1; s0_we = 0; s0_addr = 8'h40;
    step();
    check("t5_grant", 32'(grant), 32'd1);
    check("t5_m_addr", 32'(m_addr), 32'h40);
    check_s1_blocked("t5a");
    s1_cyc = 1;
    step();
    check_s1_blocked("t5b");
    s0_addr = 8'h41; m_ack = 1; m_ds2m = 8'h11;
    exp_q.push_back('{0, 8'h11});
    step();
    check_s1_blocked("t5c");
    s0_addr = 8'h42; m_ds2m = 8'h22;
    exp_q.push_back('{0, 8'h22});
    step();
    check_s1_blocked("t5d");
    s0_stb = 0; m_ds2m = 8'h33;
    exp_q.push_back('{0, 8'h33});
    step();
    check_s1_blocked("t5e");
    m_ack = 0; s0_cyc = 0;
    step();
    check("t5_idle", 32'(grant), 32'd0);
    check("t5_s0_acks", 32'(s0_ack_cnt - base0), 32'd3);
    check("t5_s1_acks", 32'(s1_ack_cnt - base1), 32'd0);
    step();
    check("t5_s1_grant", 32'(grant), 32'd2);
    check("t5_s1_stall_owner", 32'(s1_stall), 32'd0);
    check("t5_s0_stall_nonowner", 32'(s0_stall), 32'd1);
    s1_cyc = 0;
    step();
    check("t5_end_idle", 32'(grant), 32'd0);

    // 6: asynchronous reset in the middle of a burst
    s0_cyc = 1; s0_stb = 1; s0_addr = 8'h50;
    step();
    check("t6_grant", 32'(grant), 32'd1);
    check("t6_m_cyc", 32'(m_cyc), 32'd1);
    #2 aresetn = 1'b0;
    #1 m_ack = 1; m_ds2m = 8'h99;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_m_cyc", 32'(m_cyc), 32'd0);
    check("t6_rst_m_stb", 32'(m_stb), 32'd0);
    check("t6_rst_s0_stall", 32'(s0_stall), 32'd1);
    check("t6_rst_s1_stall", 32'(s1_stall), 32'd1);
    check("t6_rst_s0_ack", 32'(s0_ack), 32'd0);
    m_ack = 0; s0_cyc = 0; s0_stb = 0;
    step();
    step();
    #3 aresetn = 1'b1;
    step();
    check("t6_post_grant", 32'(grant), 32'd0);

    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
